// File: rtl/instr_prefetch_buffer_pkg.sv
// rtl/instr_prefetch_buffer_pkg.sv - shared FSM encodings and defaults for the instruction prefetch buffer
package instr_prefetch_buffer_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int PC_W_DEF  = 10;
  localparam int IW_DEF    = 32;

  // Canonical no-op (addi x0,x0,0) for consumers that need a filler word.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } ipb_state_e;

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// rtl/instr_prefetch_buffer_if.sv - redirect, IMEM and decode-side signal bundle of the prefetch buffer
interface ipb_if
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int IW    = IW_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic [IW-1:0]   imem_data;
  logic            deq_ready;
  logic            deq_valid;
  logic [IW-1:0]   instr_out;
  logic [PC_W-1:0] pc_out;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;

  modport slave (
    input  redirect, redirect_pc, imem_data, deq_ready,
    output imem_addr, imem_req, deq_valid, instr_out, pc_out, full, empty, count
  );

  modport master (
    output redirect, redirect_pc, imem_data, deq_ready,
    input  imem_addr, imem_req, deq_valid, instr_out, pc_out, full, empty, count
  );

endinterface

// File: rtl/instr_prefetch_buffer_fifo_mem.sv
// rtl/instr_prefetch_buffer_fifo_mem.sv - circular DEPTH-entry store with read/write pointers and count
module ipb_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 42,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - fetch PC, IMEM request/response tracking and redirect FSM over the FIFO
// IPB_BYPASS_EN: when defined, a response arriving at an empty buffer is presented in the same cycle.
module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PC_W  = PC_W_DEF,
  parameter int IW    = IW_DEF
) (
  input logic  clk,
  input logic  rst,
  ipb_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = IW + PC_W;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  ipb_state_e      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   head;
  logic [CW:0]     occ;
  logic [CW:0]     occ_nx;
  logic            req, resp_live, bypass, fifo_wr, fifo_rd, fire;

  // Occupancy includes the slot reserved by an outstanding request.
  assign occ       = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);
  assign req       = rst & (state_q == S_RUN) & ~bus.redirect & (occ < DEPTH_W);
  assign resp_live = inflight_q & ~bus.redirect;

`ifdef IPB_BYPASS_EN
  assign bypass = resp_live & (fifo_count == '0) & bus.deq_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = resp_live & ~bypass;
  assign fire    = bus.deq_valid & bus.deq_ready & ~bus.redirect;
  assign fifo_rd = fire & ~bypass;

  ipb_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.redirect),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({bus.imem_data, req_pc_q}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (head),
    .count_o   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    occ_nx     = (CW+1)'(fifo_count) + (CW+1)'(fifo_wr) - (CW+1)'(fifo_rd) + (CW+1)'(req);
    if (req) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      req_pc_d   = fetch_pc_q;
    end
    if (bus.redirect) begin
      state_d    = S_FLUSH;
      fetch_pc_d = bus.redirect_pc;
      inflight_d = 1'b0;
    end else begin
      state_d = (occ_nx == DEPTH_W) ? S_FULL : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    bus.instr_out = '0;
    bus.pc_out    = '0;
    if (bypass) begin
      bus.instr_out = bus.imem_data;
      bus.pc_out    = req_pc_q;
    end else if (fifo_count != '0) begin
      bus.instr_out = head[EW-1:PC_W];
      bus.pc_out    = head[PC_W-1:0];
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.imem_req  = req;
  assign bus.deq_valid = (fifo_count != '0) | bypass;
  assign bus.full      = (fifo_count == CW'(DEPTH));
  assign bus.empty     = (fifo_count == '0);
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - directed scoreboard bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 8;
  localparam int PC_W  = 10;
  localparam int IW    = 32;
`ifdef IPB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n_fire = 0;
  logic [PC_W-1:0] sb_q[$];
  logic [PC_W-1:0] mon_pc;

  ipb_if #(.DEPTH(DEPTH), .PC_W(PC_W), .IW(IW)) bus ();

  instr_prefetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] imem_fn(input logic [PC_W-1:0] a);
    return {16'hC0DE, 6'h00, a};
  endfunction

  // IMEM: one-cycle synchronous read, data encodes the address
  always @(posedge clk) bus.imem_data <= imem_fn(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head entry must match the next expected PC
  always @(negedge clk) begin
    if (rst && bus.deq_valid && bus.deq_ready && !bus.redirect) begin
      n_fire++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_pop: observed fire pc=%0h expected none (scoreboard empty)", bus.pc_out);
      end
      if (sb_q.size() != 0) begin
        mon_pc = sb_q.pop_front();
        chk("sb_pc", bus.pc_out, mon_pc);
        chk("sb_instr", bus.instr_out, imem_fn(mon_pc));
      end
    end
  end

  initial begin
    int nreq;
    int f0;
    int k;
    rst = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.deq_ready = 1'b0;
    tick();
    tick();

    chk("rst_req", bus.imem_req, 0);
    chk("rst_dv", bus.deq_valid, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_instr", bus.instr_out, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_addr", bus.imem_addr, 0);

    // streaming with decode always ready
    for (int i = 0; i < 30; i++) sb_q.push_back(PC_W'(i));
    f0 = n_fire;
    rst = 1'b1;
    bus.deq_ready = 1'b1;
    #1;
    chk("p1_req0", bus.imem_req, 1);
    chk("p1_addr0", bus.imem_addr, 0);
    chk("p1_dv0", bus.deq_valid, 0);
    tick();
    chk("p1_dv1", bus.deq_valid, BYP);
    chk("p1_pc1", bus.pc_out, 0);
    tick();
    chk("p1_dv2", bus.deq_valid, 1);
    chk("p1_pc2", bus.pc_out, BYP ? 1 : 0);
    repeat (20) tick();
    chk("p1_fires", (n_fire - f0) >= 20, 1);
    rst = 1'b0;
    bus.deq_ready = 1'b0;
    tick();
    sb_q.delete();

    // fill to full with decode stalled
    rst = 1'b1;
    #1;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.imem_req) nreq++;
      tick();
    end
    chk("p2_nreq", nreq, 8);
    chk("p2_full", bus.full, 1);
    chk("p2_count", bus.count, 8);
    chk("p2_req_off", bus.imem_req, 0);
    chk("p2_dv", bus.deq_valid, 1);
    for (int i = 0; i < 16; i++) sb_q.push_back(PC_W'(i));
    bus.deq_ready = 1'b1;
    #1;
    chk("p2_hold", bus.imem_req, 0);
    tick();
    chk("p2_resume", bus.imem_req, 1);
    chk("p2_addr", bus.imem_addr, 8);
    chk("p2_notfull", bus.full, 0);
    repeat (6) tick();
    rst = 1'b0;
    bus.deq_ready = 1'b0;
    tick();
    sb_q.delete();

    // redirect with 5 entries buffered and one response in flight
    rst = 1'b1;
    repeat (6) tick();
    chk("p3_count5", bus.count, 5);
    chk("p3_req", bus.imem_req, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'h1F0;
    #1;
    chk("p3_req_gated", bus.imem_req, 0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("p3_count0", bus.count, 0);
    chk("p3_empty", bus.empty, 1);
    chk("p3_dv", bus.deq_valid, 0);
    chk("p3_flush_noreq", bus.imem_req, 0);
    for (int i = 0; i < 8; i++) sb_q.push_back(PC_W'(10'h1F0 + i));
    bus.deq_ready = 1'b1;
    tick();
    chk("p3_req_new", bus.imem_req, 1);
    chk("p3_addr_new", bus.imem_addr, 10'h1F0);
    k = 0;
    while (!bus.deq_valid && k < 5) begin
      tick();
      k++;
    end
    chk("p3_dv_seen", bus.deq_valid, 1);
    chk("p3_first_pc", bus.pc_out, 10'h1F0);

    // PC wrap at 0x3FF and pointer wrap over a long stream
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'h3FE;
    sb_q.delete();
    sb_q.push_back(10'h3FE);
    sb_q.push_back(10'h3FF);
    for (int i = 0; i < 40; i++) sb_q.push_back(PC_W'(i));
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("p4_addr3fe", bus.imem_addr, 10'h3FE);
    tick();
    chk("p4_addr3ff", bus.imem_addr, 10'h3FF);
    tick();
    chk("p4_wrap", bus.imem_addr, 10'h000);
    f0 = n_fire;
    repeat (22) tick();
    chk("p4_fires", (n_fire - f0) >= 20, 1);

    // reset while full with redirect asserted
    bus.deq_ready = 1'b0;
    k = 0;
    while (!bus.full && k < 30) begin
      tick();
      k++;
    end
    chk("p5_full", bus.full, 1);
    rst = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'h123;
    #1;
    chk("p5_req_rst", bus.imem_req, 0);
    tick();
    chk("p5_count", bus.count, 0);
    chk("p5_empty", bus.empty, 1);
    chk("p5_full0", bus.full, 0);
    chk("p5_dv", bus.deq_valid, 0);
    chk("p5_pc", bus.pc_out, 0);
    chk("p5_instr", bus.instr_out, 0);
    chk("p5_addr", bus.imem_addr, 0);
    rst = 1'b1;
    bus.redirect = 1'b0;
    #1;
    chk("p5_req_after", bus.imem_req, 1);
    chk("p5_addr_after", bus.imem_addr, 0);
    tick();
    chk("p5_addr_next", bus.imem_addr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
